// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_stage_sequencer - stage/address sequencer for in-place radix-2 DIT FFT
// Revision: 1.0
// ---------------------------------------------------------------------------
module fft_stage_sequencer #(
  parameter int MAX_LOG2_N = 10,
  parameter int ADDR_W     = MAX_LOG2_N
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [3:0]        log2_n_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [ADDR_W-2:0] tw_addr_o,
  input  logic              wb_valid_i,
  output logic [3:0]        stage_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] C_MAX_L = 4'(MAX_LOG2_N);

  state_t            state_q;
  logic [3:0]        l_q, s_q;
  logic [ADDR_W-1:0] j_q, out_q;

  logic              hs, legal, last_bfly;
  logic [3:0]        l_d, s_d;
  logic [ADDR_W-1:0] j_d, half_d, k_d, g_d, addr_a_d, addr_b_d;
  logic [ADDR_W-2:0] tw_d;

  assign hs        = rd_valid_o & rd_ready_i;
  assign legal     = (log2_n_i >= 4'd2) && (log2_n_i <= C_MAX_L);
  assign last_bfly = (j_q == ((ADDR_W'(1) << (l_q - 4'd1)) - ADDR_W'(1)));

  // Address of the request that will be presented next: first of a run,
  // next in this stage, or first of the following stage.
  always_comb begin
    l_d = (state_q == S_IDLE) ? log2_n_i : l_q;
    j_d = '0;
    s_d = '0;
    case (state_q)
      S_ISSUE: begin
        j_d = j_q + ADDR_W'(1);
        s_d = s_q;
      end
      S_DRAIN: s_d = s_q + 4'd1;
      default: ;
    endcase
    half_d   = ADDR_W'(1) << s_d;
    k_d      = j_d & (half_d - ADDR_W'(1));
    g_d      = j_d >> s_d;
    addr_a_d = (g_d << (s_d + 4'd1)) | k_d;
    addr_b_d = addr_a_d + half_d;
    tw_d     = k_d[ADDR_W-2:0] << (l_d - 4'd1 - s_d);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      l_q         <= '0;
      s_q         <= '0;
      j_q         <= '0;
      out_q       <= '0;
      rd_valid_o  <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      tw_addr_o   <= '0;
      stage_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else if (abort_i) begin
      state_q    <= S_IDLE;
      s_q        <= '0;
      j_q        <= '0;
      out_q      <= '0;
      rd_valid_o <= 1'b0;
      stage_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      // Writeback with nothing outstanding is a protocol error; count saturates at 0.
      if (hs && !wb_valid_i) begin
        out_q <= out_q + ADDR_W'(1);
      end else if (!hs && wb_valid_i) begin
        if (out_q == '0) error_o <= 1'b1;
        else             out_q   <= out_q - ADDR_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (legal) begin
              l_q         <= log2_n_i;
              s_q         <= '0;
              j_q         <= '0;
              out_q       <= '0;
              error_o     <= 1'b0;
              state_q     <= S_ISSUE;
              rd_valid_o  <= 1'b1;
              busy_o      <= 1'b1;
              stage_o     <= '0;
              rd_addr_a_o <= addr_a_d;
              rd_addr_b_o <= addr_b_d;
              tw_addr_o   <= tw_d;
            end else begin
              error_o <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (hs) begin
            if (last_bfly) begin
              state_q    <= S_DRAIN;
              rd_valid_o <= 1'b0;
            end else begin
              j_q         <= j_d;
              rd_addr_a_o <= addr_a_d;
              rd_addr_b_o <= addr_b_d;
              tw_addr_o   <= tw_d;
            end
          end
        end
        S_DRAIN: begin
          if (out_q == '0) begin
            if (s_q == l_q - 4'd1) begin
              state_q <= S_DONE;
              done_o  <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              s_q         <= s_d;
              j_q         <= '0;
              stage_o     <= s_d;
              rd_valid_o  <= 1'b1;
              rd_addr_a_o <= addr_a_d;
              rd_addr_b_o <= addr_b_d;
              tw_addr_o   <= tw_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_stage_sequencer - directed bench with butterfly-order model and writeback scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fft_stage_sequencer;

  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          reset_n_i, start_i, abort_i, rd_ready_i, wb_valid_i;
  logic [3:0]    log2_n_i;
  logic          rd_valid_o, busy_o, done_o, error_o;
  logic [AW-1:0] rd_addr_a_o, rd_addr_b_o;
  logic [AW-2:0] tw_addr_o;
  logic [3:0]    stage_o;

  always #5 clk_i = ~clk_i;

  fft_stage_sequencer #(.MAX_LOG2_N(10), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .abort_i(abort_i),
    .log2_n_i(log2_n_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
    .wb_valid_i(wb_valid_i), .stage_o(stage_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o)
  );

  typedef struct { int a; int b; int tw; int s; } bfly_t;

  bfly_t exp_q[$];
  int    wb_due[$];
  int    n_checks = 0, n_fail = 0;
  int    cyc = 0, hs_cnt = 0, done_cnt = 0, last_wb_cyc = -100;
  int    wb_delay = 3, hold_hs = -1, hold_len = 20, ready_mode = 0, stall = 0;
  logic  force_wb = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int pack3(input int a, input int b, input int tw);
    return (a << (2*AW-1)) | (b << (AW-1)) | tw;
  endfunction

  // Textbook in-place DIT ordering: per stage, groups of 2*half, butterflies within a group.
  function automatic void fill_exp(input int L);
    int n;
    bfly_t e;
    n = 1 << L;
    for (int s = 0; s < L; s++) begin
      for (int base = 0; base < n; base += (2 << s)) begin
        for (int k = 0; k < (1 << s); k++) begin
          e.a  = base + k;
          e.b  = base + k + (1 << s);
          e.tw = k * (n / (2 << s));
          e.s  = s;
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  // Writeback scheduler and ready driver, updated just after each rising edge.
  initial begin
    rd_ready_i = 1'b0;
    wb_valid_i = 1'b0;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      wb_valid_i = force_wb;
      if (wb_due.size() > 0 && wb_due[0] <= cyc) begin
        void'(wb_due.pop_front());
        wb_valid_i = 1'b1;
      end
      if (ready_mode == 0) begin
        rd_ready_i = 1'b1;
      end else if (!rd_valid_o) begin
        rd_ready_i = 1'b0;
        stall = 0;
      end else if (stall < 2) begin
        rd_ready_i = 1'b0;
        stall++;
      end else begin
        rd_ready_i = 1'b1;
        stall = 0;
      end
    end
  end

  // Compare process: samples on the falling edge.
  initial begin
    bfly_t         e;
    logic          pv, pr, pd, plive;
    logic [3*AW-2:0] ptrip;
    logic [3:0]    pstage;
    pv = 1'b0; pr = 1'b0; pd = 1'b0; plive = 1'b0; ptrip = '0; pstage = '0;
    forever begin
      @(negedge clk_i);
      if (plive && pv && !pr) begin
        check("hold_valid", rd_valid_o, 1);
        check("hold_addr", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, ptrip);
        check("hold_stage", stage_o, pstage);
      end
      if (!pv && rd_valid_o && stage_o != 4'd0)
        check("barrier_release_cycle", cyc, last_wb_cyc + 2);
      if (done_o) begin
        done_cnt++;
        check("done_one_cycle", pd, 0);
        check("done_timing", cyc, last_wb_cyc + 2);
        check("busy_with_done", busy_o, 1);
      end else if (pd) begin
        check("busy_falls_with_done", busy_o, 0);
      end
      if (reset_n_i && !abort_i && rd_valid_o && rd_ready_i) begin
        check("model_has_entry", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bfly_addr", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, pack3(e.a, e.b, e.tw));
          check("bfly_stage", stage_o, e.s);
        end
        wb_due.push_back(cyc + ((hs_cnt == hold_hs) ? hold_len : wb_delay));
        hs_cnt++;
      end
      if (wb_valid_i) last_wb_cyc = cyc;
      pv = rd_valid_o; pr = rd_ready_i; pd = done_o;
      plive = reset_n_i && !abort_i;
      ptrip = {rd_addr_a_o, rd_addr_b_o, tw_addr_o};
      pstage = stage_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic start_run(input int L);
    fill_exp(L);
    tick();
    start_i = 1'b1; log2_n_i = 4'(L);
    tick();
    start_i = 1'b0; log2_n_i = 4'd7;
    @(negedge clk_i);
    check("first_req_valid", rd_valid_o, 1);
    check("busy_on_start", busy_o, 1);
    check("error_cleared_on_start", error_o, 0);
  endtask

  task automatic illegal_start(input int L);
    tick();
    start_i = 1'b1; log2_n_i = 4'(L);
    tick();
    start_i = 1'b0;
    @(negedge clk_i);
    check("error_illegal", error_o, 1);
    check("busy_illegal", busy_o, 0);
    check("valid_illegal", rd_valid_o, 0);
    repeat (3) @(negedge clk_i);
    check("valid_stays_low", rd_valid_o, 0);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("done_within_budget", int'(done_cnt > d0), 1);
    repeat (2) @(negedge clk_i);
    check("done_pulse_count", done_cnt - d0, 1);
    check("busy_after_done", busy_o, 0);
    check("model_drained", exp_q.size(), 0);
  endtask

  initial begin
    int h0, d0, n;
    reset_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; log2_n_i = 4'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ctrl", {rd_valid_o, busy_o, done_o, error_o}, 0);
    check("rst_addr", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, 0);
    check("rst_stage", stage_o, 0);
    tick();
    reset_n_i = 1'b1;

    // Pin the model against hand-computed orderings.
    fill_exp(2);
    check("model_n4_0", pack3(exp_q[0].a, exp_q[0].b, exp_q[0].tw), pack3(0, 1, 0));
    check("model_n4_1", pack3(exp_q[1].a, exp_q[1].b, exp_q[1].tw), pack3(2, 3, 0));
    check("model_n4_2", pack3(exp_q[2].a, exp_q[2].b, exp_q[2].tw), pack3(0, 2, 0));
    check("model_n4_3", pack3(exp_q[3].a, exp_q[3].b, exp_q[3].tw), pack3(1, 3, 1));
    exp_q.delete();
    fill_exp(3);
    check("model_n8_size", exp_q.size(), 12);
    check("model_n8_5", pack3(exp_q[5].a, exp_q[5].b, exp_q[5].tw), pack3(1, 3, 2));
    check("model_n8_11", pack3(exp_q[11].a, exp_q[11].b, exp_q[11].tw), pack3(3, 7, 3));
    exp_q.delete();

    // N=4, ready high, writeback 3 cycles after each request
    ready_mode = 0; wb_delay = 3;
    h0 = hs_cnt; d0 = done_cnt;
    start_run(2);
    wait_done(d0, 200);
    check("n4_handshakes", hs_cnt - h0, 4);
    check("n4_error", error_o, 0);

    // N=8, ready low for two cycles per request
    ready_mode = 1;
    h0 = hs_cnt; d0 = done_cnt;
    start_run(3);
    wait_done(d0, 400);
    check("n8_handshakes", hs_cnt - h0, 12);
    ready_mode = 0;

    // Illegal sizes
    d0 = done_cnt;
    illegal_start(1);
    illegal_start(11);
    check("no_done_illegal", done_cnt - d0, 0);

    // Legal start clears error; writeback coincides with next handshake
    wb_delay = 1;
    h0 = hs_cnt; d0 = done_cnt;
    start_run(3);
    wait_done(d0, 400);
    check("same_cycle_handshakes", hs_cnt - h0, 12);
    check("same_cycle_error", error_o, 0);
    wb_delay = 3;

    // Spurious writeback in IDLE
    tick(); force_wb = 1'b1;
    tick(); force_wb = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    check("spurious_wb_error", error_o, 1);
    check("spurious_wb_idle", busy_o, 0);

    // Stage barrier: last writeback of stage 0 held back 20 cycles
    h0 = hs_cnt; d0 = done_cnt;
    hold_hs = hs_cnt + 3;
    start_run(3);
    wait_done(d0, 400);
    hold_hs = -1;
    check("barrier_handshakes", hs_cnt - h0, 12);
    check("barrier_error", error_o, 0);

    // Abort in stage 1
    d0 = done_cnt;
    start_run(3);
    n = 0;
    while (!(rd_valid_o && stage_o == 4'd1) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_stage1", stage_o, 1);
    tick();
    abort_i = 1'b1;
    exp_q.delete(); wb_due.delete();
    tick();
    abort_i = 1'b0;
    @(negedge clk_i);
    check("abort_valid", rd_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_stage", stage_o, 0);
    repeat (10) @(negedge clk_i);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_error", error_o, 0);

    // Reset in the middle of a fresh run
    h0 = hs_cnt;
    start_run(3);
    n = 0;
    while (hs_cnt < h0 + 6 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_mid_run", int'(hs_cnt >= h0 + 6), 1);
    tick();
    reset_n_i = 1'b0;
    exp_q.delete(); wb_due.delete();
    tick();
    @(negedge clk_i);
    check("midrst_ctrl", {rd_valid_o, busy_o, done_o, error_o}, 0);
    check("midrst_addr", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, 0);
    check("midrst_stage", stage_o, 0);
    tick();
    reset_n_i = 1'b1;

    // Clean run after reset
    h0 = hs_cnt; d0 = done_cnt;
    start_run(2);
    wait_done(d0, 200);
    check("post_rst_handshakes", hs_cnt - h0, 4);
    check("post_rst_error", error_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Address and stage sequencer for the in-place radix-2 DIT FFT engine inside `fft_top`. On `start_i` it walks all log2(N) stages, issuing one butterfly read request per handshake with the butterfly-pair address and twiddle index. It enforces a stage barrier by counting outstanding writebacks, and reports completion or error to the control/status path. It sits between the APB register block (start, size) and the butterfly datapath/sample RAM.

## Interface

Parameters:
- `MAX_LOG2_N`, default 10: largest supported FFT size (N = 1024).
- `ADDR_W`, default `MAX_LOG2_N`: sample RAM address width.

Ports:
- `clk_i`  in  1  core clock; single clock domain.
- `reset_n_i`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  start pulse; honoured only in IDLE.
- `abort_i`  in  1  abort; returns to IDLE from any state.
- `log2_n_i`  in  4  FFT size exponent, sampled on accepted start; legal range 2..`MAX_LOG2_N`.
- `rd_valid_o`  out  1  butterfly request valid.
- `rd_ready_i`  in  1  butterfly engine accepts the request.
- `rd_addr_a_o`  out  `ADDR_W`  upper-leg address.
- `rd_addr_b_o`  out  `ADDR_W`  lower-leg address.
- `tw_addr_o`  out  `ADDR_W`-1  twiddle ROM index.
- `wb_valid_i`  in  1  one butterfly result written back (1 per request).
- `stage_o`  out  4  current stage index.
- `busy_o`  out  1  high in ISSUE/DRAIN/DONE.
- `done_o`  out  1  one-cycle completion pulse.
- `error_o`  out  1  sticky error; cleared on next accepted start or reset.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start_i` with legal `log2_n_i`: latch L = `log2_n_i`; clear stage s, butterfly count j and outstanding count; clear `error_o`; go to ISSUE.
  - `start_i` with illegal `log2_n_i` (<2 or >`MAX_LOG2_N`): set `error_o`; stay in IDLE; no `done_o`.
- **ISSUE**
  - `rd_valid_o` = 1.
  - Butterfly j (0..N/2-1) at stage s, with half = 1<<s:
    - g = j>>s, k = j&(half-1).
    - addr_a = (g<<(s+1)) | k.
    - addr_b = addr_a + half.
    - tw = k<<(L-1-s).
  - On handshake (`rd_valid_o` & `rd_ready_i`): j++, outstanding++.
  - Handshake on j = N/2-1 goes to DRAIN.
- **DRAIN**
  - `rd_valid_o` = 0.
  - When the registered outstanding count is 0:
    - if s = L-1, go to DONE;
    - else s++, j = 0, go to ISSUE.
- **DONE**
  - `done_o` = 1 for exactly one cycle, then IDLE.
- Outstanding counter (`ADDR_W` bits)
  - Handshake increments; `wb_valid_i` decrements; both in the same cycle leave it unchanged.
  - `wb_valid_i` with the count at 0 (and no same-cycle handshake) sets `error_o`; the count holds at 0.
- `start_i` outside IDLE is ignored. `log2_n_i` changes after start have no effect.
- `abort_i` (priority over all but reset): next state IDLE; j, s and outstanding count cleared; no `done_o`; `error_o` unchanged.

## Timing

- All outputs are registered. Reset values:
  - `rd_valid_o`, `busy_o`, `done_o`, `error_o` = 0.
  - `rd_addr_a_o`, `rd_addr_b_o`, `tw_addr_o`, `stage_o` = 0.
- Accepted `start_i` in cycle t: `rd_valid_o` and the first addresses are valid at t+1.
- Valid/ready rule: while `rd_valid_o` = 1 and `rd_ready_i` = 0, all address outputs and `stage_o` are held stable. `rd_valid_o` never drops without a handshake, except on abort or reset.
- With `rd_ready_i` held high, ISSUE sustains one butterfly per cycle, i.e. N/2 cycles per stage.
- DRAIN-to-ISSUE: the first request of the next stage appears the cycle after the registered count reads 0.
- `done_o` rises the cycle after the final DRAIN sees count 0. `busy_o` falls in the same cycle `done_o` falls.
- Reset asserted mid-operation: all outputs return to reset values at the next clock edge.

## Test plan

- N=4 (`log2_n_i`=2), `rd_ready_i`=1, writeback 3 cycles after each request:
  - required (a,b,tw) sequence: (0,1,0), (2,3,0), then after drain (0,2,0), (1,3,1);
  - one `done_o` pulse; `error_o`=0.
- N=8 with `rd_ready_i` low for 2 cycles on every request: each address triple held stable until its handshake; 12 handshakes total; `stage_o` steps 0→1→2.
- `log2_n_i`=1 and `log2_n_i`=11 with start: `error_o`=1, `busy_o`=0, no `rd_valid_o`. A following legal start clears `error_o`.
- Issue handshake and `wb_valid_i` in the same cycle: outstanding count unchanged. Spurious `wb_valid_i` in IDLE: `error_o`=1.
- Stage barrier: hold back one writeback for 20 cycles; next-stage `rd_valid_o` stays low until that writeback arrives.
- `abort_i` mid-stage-1, then reset asserted mid-run of a fresh start:
  - abort: IDLE next cycle, no `done_o`;
  - reset: all outputs 0 at the next edge;
  - a new start then runs cleanly from stage 0.
